io_out_buffer: RTL and testbench

- Sits between the CPU's memory-mapped IO write path and the UART transmitter inside riscv_top.
- Buffers CPU byte writes to 0x30000 in a FIFO and drains them to the UART TX with a valid/ready handshake.
- Turns a write to 0x30004 (program end) into a halt indication once every buffered byte has left.
- Lets the CPU run ahead of the slow UART; lets the simulation bench detect the end of a test program.

---
 rtl/io_out_buffer.sv | 128 ++++++++++++
 tb/tb_io_out_buffer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/io_out_buffer.sv
// io_out_buffer: CPU IO byte FIFO feeding the UART TX, plus program-end halt.
// Optional IO_DROP_CNT_EN adds a saturating counter of rejected byte writes.
module io_out_buffer #(
   parameter int DEPTH_LOG = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        io_we_in,
   input  logic        io_sel_in,
   input  logic [7:0]  io_data_in,
   output logic        io_full_out,
   output logic [7:0]  tx_data_out,
   output logic        tx_valid_out,
   input  logic        tx_ready_in,
   output logic        empty_out,
`ifdef IO_DROP_CNT_EN
   output logic [15:0] drop_cnt_out,
`endif
   output logic        halt_out
);

   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG:0] FULL_CNT =
      {1'b1, {DEPTH_LOG{1'b0}}};

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   logic [7:0]         mem_q [DEPTH];
   logic [DEPTH_LOG:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG:0] count, count_d;
   logic               full_q, empty_q, halt_q;
   state_t             state_q;
   logic               has_data, push, pop;

   assign count    = wr_ptr_q - rd_ptr_q;
   assign has_data = (count != '0);

   // full_q is the registered flag, so a full FIFO rejects even with a pop
   assign push = rdy_in & io_we_in & ~io_sel_in & ~full_q
               & (state_q == RUN);
   assign pop  = rdy_in & has_data & tx_ready_in;

   assign wr_ptr_d = wr_ptr_q + {{DEPTH_LOG{1'b0}}, push};
   assign rd_ptr_d = rd_ptr_q + {{DEPTH_LOG{1'b0}}, pop};
   assign count_d  = wr_ptr_d - rd_ptr_d;

   assign tx_valid_out = rdy_in & has_data;
   assign tx_data_out  = has_data ? mem_q[rd_ptr_q[DEPTH_LOG-1:0]] : 8'h00;
   assign io_full_out  = full_q;
   assign empty_out    = empty_q;
   assign halt_out     = halt_q;

   // FIFO storage: cleared on reset, written on accepted byte pushes
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (push) begin
         mem_q[wr_ptr_q[DEPTH_LOG-1:0]] <= io_data_in;
      end
   end

   // Pointers and full/empty flags, flags follow the next-state count
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else if (rdy_in) begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= (count_d == FULL_CNT);
         empty_q  <= (count_d == '0);
      end
   end

   // Program-end FSM: RUN until halt write, DRAIN until empty, then HALTED
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= RUN;
         halt_q  <= 1'b0;
      end else if (rdy_in) begin
         case (state_q)
            RUN: begin
               if (io_we_in & io_sel_in) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (count_d == '0) begin
                  state_q <= HALTED;
                  halt_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= state_q;
            end
         endcase
      end
   end

`ifdef IO_DROP_CNT_EN
   logic [15:0] drop_q;
   logic        drop;

   assign drop = rdy_in & io_we_in & ~io_sel_in
               & (full_q | (state_q != RUN));
   assign drop_cnt_out = drop_q;

   // Saturating count of byte writes that were thrown away
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         drop_q <= 16'h0000;
      end else if (drop && (drop_q != 16'hFFFF)) begin
         drop_q <= drop_q + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_io_out_buffer.sv
// tb_io_out_buffer: directed plus random stimulus against a queue model.
// Checks every output each cycle and the delivered byte stream.
module tb_io_out_buffer;

   localparam int DEPTH = 16;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, io_we_in, io_sel_in, tx_ready_in;
   logic [7:0]  io_data_in;
   logic        io_full_out, tx_valid_out, empty_out, halt_out;
   logic [7:0]  tx_data_out;
`ifdef IO_DROP_CNT_EN
   logic [15:0] drop_cnt_out;
`endif

   io_out_buffer #(.DEPTH_LOG(4)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rdy_in       (rdy_in),
      .io_we_in     (io_we_in),
      .io_sel_in    (io_sel_in),
      .io_data_in   (io_data_in),
      .io_full_out  (io_full_out),
      .tx_data_out  (tx_data_out),
      .tx_valid_out (tx_valid_out),
      .tx_ready_in  (tx_ready_in),
      .empty_out    (empty_out),
`ifdef IO_DROP_CNT_EN
      .drop_cnt_out (drop_cnt_out),
`endif
      .halt_out     (halt_out)
   );

   always #5 clk_in = ~clk_in;

   int n_pass = 0;
   int n_tot  = 0;

   logic [7:0] q[$];
   logic [7:0] got[$];
   int         st;
   int         drops;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      q.delete();
      st    = 0;
      drops = 0;
   endtask

   task automatic cyc(input logic rst, input logic rdy, input logic we,
                      input logic sel, input logic [7:0] d,
                      input logic txr);
      logic is_byte, do_pop, do_push;
      rst_in      = rst;
      rdy_in      = rdy;
      io_we_in    = we;
      io_sel_in   = sel;
      io_data_in  = d;
      tx_ready_in = txr;
      #1;
      chk("tx_valid", tx_valid_out, 16'(rdy && q.size() != 0));
      chk("tx_data", tx_data_out, q.size() != 0 ? 16'(q[0]) : 16'h0);
      chk("io_full", io_full_out, 16'(q.size() == DEPTH));
      chk("empty", empty_out, 16'(q.size() == 0));
      chk("halt", halt_out, 16'(st == 2));
`ifdef IO_DROP_CNT_EN
      chk("drop_cnt", drop_cnt_out, 16'(drops));
`endif
      if (!rst && tx_valid_out && txr) got.push_back(tx_data_out);
      if (rst) begin
         model_reset();
      end else if (rdy) begin
         is_byte = we && !sel;
         do_pop  = (q.size() != 0) && txr;
         do_push = is_byte && (q.size() != DEPTH) && (st == 0);
         if (is_byte && !do_push && drops < 65535) drops++;
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(d);
         if (st == 0 && we && sel) st = 1;
         else if (st == 1 && q.size() == 0) st = 2;
      end
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle(input logic txr);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, txr);
   endtask

   task automatic wr(input logic [7:0] d, input logic txr);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, d, txr);
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; io_we_in = 1'b0;
      io_sel_in = 1'b0; io_data_in = 8'h00; tx_ready_in = 1'b0;
      @(posedge clk_in);
      #1;
      model_reset();
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

      // single byte, latency one, popped immediately
      got.delete();
      wr(8'h41, 1'b1);
      chk("t1_valid", tx_valid_out, 16'h1);
      chk("t1_data", tx_data_out, 16'h41);
      idle(1'b1);
      chk("t1_empty", empty_out, 16'h1);
      chk("t1_got", got.size() == 1 ? 16'(got[0]) : 16'hFFFF, 16'h41);

      // fill to full, reject one, drain in order
      got.delete();
      for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
      chk("t2_full", io_full_out, 16'h1);
      wr(8'hFF, 1'b0);
`ifdef IO_DROP_CNT_EN
      chk("t2_drop", drop_cnt_out, 16'h1);
`endif
      for (int i = 0; i < 18; i++) idle(1'b1);
      chk("t2_n", 16'(got.size()), 16'd16);
      for (int i = 0; i < 16 && i < got.size(); i++)
         chk("t2_byte", 16'(got[i]), 16'(i));

      // 20 bytes with toggling ready across pointer wrap
      got.delete();
      for (int i = 0; i < 20; i++) wr(8'(8'h80 + i), 1'(i % 2));
      for (int i = 0; i < 16; i++) idle(1'b1);
      chk("t3_n", 16'(got.size()), 16'd20);
      for (int i = 0; i < 20 && i < got.size(); i++)
         chk("t3_byte", 16'(got[i]), 16'(8'h80 + i));

      // three bytes, halt, late byte is ignored
      got.delete();
      for (int i = 0; i < 3; i++) wr(8'(8'hA0 + i), 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
      wr(8'h55, 1'b1);
      for (int i = 0; i < 6; i++) idle(1'b1);
      chk("t4_n", 16'(got.size()), 16'd3);
      chk("t4_halt", halt_out, 16'h1);
      for (int i = 0; i < 3 && i < got.size(); i++)
         chk("t4_byte", 16'(got[i]), 16'(8'hA0 + i));

      // halt on empty FIFO, then reset clears it
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
      chk("t5_halt1", halt_out, 16'h0);
      idle(1'b0);
      chk("t5_halt2", halt_out, 16'h1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("t5_rhalt", halt_out, 16'h0);
      chk("t5_rempty", empty_out, 16'h1);
      chk("t5_rdata", tx_data_out, 16'h0);

      // global enable low freezes everything
      got.delete();
      wr(8'h11, 1'b0);
      wr(8'h22, 1'b0);
      for (int i = 0; i < 5; i++)
         cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1);
      chk("t6_frozen", 16'(got.size()), 16'd0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      chk("t6_n", 16'(got.size()), 16'd2);

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic r_rst, r_we;
         r_rst = ($urandom % 100 == 0) || (st == 2 && $urandom % 8 == 0);
         r_we  = 1'($urandom % 2);
         cyc(r_rst, 1'($urandom % 8 != 0), r_we,
             r_we && ($urandom % 40 == 0), 8'($urandom),
             1'($urandom % 3 != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
